// File: rtl/l2_bank_rr_arbiter.sv
// l2_bank_rr_arbiter: round-robin sharing of one single-ported L2 bank among
// NB_MASTERS requesters, with a zero-fill sequencer that clears the whole bank.
module l2_bank_rr_arbiter #(
    parameter int NB_MASTERS = 4,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int BANK_SIZE  = 16384
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             init_req_i,
    output logic                             init_busy_o,
    output logic                             init_done_o,
    input  logic [NB_MASTERS-1:0]            req_i,
    input  logic [NB_MASTERS*ADDR_WIDTH-1:0] add_i,
    input  logic [NB_MASTERS-1:0]            wen_i,
    input  logic [NB_MASTERS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NB_MASTERS*DATA_WIDTH-1:0] wdata_i,
    output logic [NB_MASTERS-1:0]            gnt_o,
    output logic [NB_MASTERS-1:0]            r_valid_o,
    output logic [DATA_WIDTH-1:0]            r_rdata_o,
    output logic                             mem_csn_o,
    output logic                             mem_wen_o,
    output logic [DATA_WIDTH/8-1:0]          mem_be_o,
    output logic [ADDR_WIDTH-1:0]            mem_add_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);
    localparam int IDX_W = NB_MASTERS > 1 ? $clog2(NB_MASTERS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef enum logic {ARB, INIT} state_t;

    state_t                state;
    logic [IDX_W-1:0]      rr_q, resp_idx_q, win, sel;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  resp_vld_q, found, grant, init;

    // First requester at or after rr_q, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            if (!found && req_i[(int'(rr_q) + i) % NB_MASTERS]) begin
                found = 1'b1;
                win   = IDX_W'((int'(rr_q) + i) % NB_MASTERS);
            end
        end
    end

    assign init  = (state == INIT);
    assign grant = found && !init;
    assign sel   = grant ? win : '0;

    assign gnt_o       = grant ? NB_MASTERS'(1) << win : '0;
    assign r_valid_o   = resp_vld_q ? NB_MASTERS'(1) << resp_idx_q : '0;
    assign r_rdata_o   = mem_rdata_i;
    assign mem_csn_o   = !(grant || init);
    assign mem_wen_o   = init ? 1'b0 : wen_i[sel];
    assign mem_be_o    = init ? '1 : be_i[int'(sel)*BE_W +: BE_W];
    assign mem_add_o   = init ? cnt_q : add_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_wdata_o = init ? '0 : wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ARB;
            rr_q        <= '0;
            cnt_q       <= '0;
            resp_vld_q  <= 1'b0;
            resp_idx_q  <= '0;
            init_busy_o <= 1'b0;
            init_done_o <= 1'b0;
        end else begin
            resp_vld_q  <= grant;
            init_done_o <= 1'b0;
            if (grant) begin
                resp_idx_q <= win;
                rr_q       <= (win == IDX_W'(NB_MASTERS - 1)) ? '0 : win + 1'b1;
            end
            if (state == ARB) begin
                if (init_req_i) begin
                    state       <= INIT;
                    cnt_q       <= '0;
                    init_busy_o <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(BANK_SIZE - 1)) begin
                    state       <= ARB;
                    init_busy_o <= 1'b0;
                    init_done_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/l2_bank_rr_arbiter.md
# l2_bank_rr_arbiter

Shares one single-ported L2 SRAM bank between NB_MASTERS TCDM-style requesters using round-robin arbitration and routes the 1-cycle-latency read/write response back to the winner. Also contains a zero-fill sequencer that clears the whole bank on request, blocking all masters while it runs. Sits between the SoC-side master ports and one interleaved or private L2 bank macro (active-low csn/wen, active-high be).

## Interface
- NB_MASTERS, 4: number of requesters; legal range 1..16.
- ADDR_WIDTH, 14: word-address width to the bank.
- DATA_WIDTH, 32: data width; be width is DATA_WIDTH/8.
- BANK_SIZE, 16384: words cleared by zero-fill; must be ≤ 2**ADDR_WIDTH.

- clk_i  in  1  clock. Single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- init_req_i  in  1  single-cycle request to start zero-fill.
- init_busy_o  out  1  high while zero-fill runs.
- init_done_o  out  1  one-cycle pulse after the last zero-fill write.
- req_i  in  NB_MASTERS  per-master request.
- add_i  in  NB_MASTERS*ADDR_WIDTH  per-master word address.
- wen_i  in  NB_MASTERS  per-master: 0 = write, 1 = read.
- be_i  in  NB_MASTERS*DATA_WIDTH/8  per-master byte enables.
- wdata_i  in  NB_MASTERS*DATA_WIDTH  per-master write data.
- gnt_o  out  NB_MASTERS  one-hot (or zero) grant, combinational, same cycle as req.
- r_valid_o  out  NB_MASTERS  response valid, one cycle after grant.
- r_rdata_o  out  DATA_WIDTH  read data, broadcast to all masters.
- mem_csn_o  out  1  bank chip select, active low.
- mem_wen_o  out  1  bank write enable, active low.
- mem_be_o  out  DATA_WIDTH/8  bank byte enables, active high.
- mem_add_o  out  ADDR_WIDTH  bank word address.
- mem_wdata_o  out  DATA_WIDTH  bank write data.
- mem_rdata_i  in  DATA_WIDTH  bank read data, valid one cycle after csn low.

## Operation
- FSM states: ARB and INIT. Reset state is ARB.
- In ARB, the winner is the first requesting master at or after rr_q, searching upward with wrap-around.
- Winner's gnt_o is set. mem_* is driven from the winner's add/wen/be/wdata, and mem_csn_o=0.
- If no master requests, gnt_o=0 and mem_csn_o=1. mem_add/wdata/be/wen then hold the master 0 values; they are don't-care.
- On a grant, rr_q <= (winner+1) mod NB_MASTERS. With no grant, rr_q holds.
- Requests are never queued. An ungranted master keeps req_i high and is served within NB_MASTERS grant cycles.
- Response path: registers resp_vld_q and resp_idx_q.
- r_valid_o[resp_idx_q] = resp_vld_q for both reads and writes.
- r_rdata_o = mem_rdata_i combinationally. It is meaningful only for read responses.
- ARB→INIT: when init_req_i=1 in ARB. Requests in that same cycle are still arbitrated and granted normally. The counter cnt_q is set to 0.
- INIT: gnt_o=0 and masters are blocked. Each cycle drives mem_csn_o=0, mem_wen_o=0, mem_be_o=all-ones, mem_wdata_o=0, mem_add_o=cnt_q. Then cnt_q++.
- INIT→ARB: after the write at cnt_q = BANK_SIZE-1. init_done_o pulses in the first ARB cycle.
- init_req_i during INIT is ignored; there is no restart.
- init_busy_o = (state == INIT), registered from the FSM.
- A response owed from the last ARB grant is still delivered in the first INIT cycle.
- Zero-fill writes never raise r_valid_o.

## Timing
- Reset values: state=ARB, rr_q=0, cnt_q=0, resp_vld_q=0, resp_idx_q=0, init_busy_o=0, init_done_o=0, r_valid_o=0.
- With no requests at reset, mem_csn_o=1 and gnt_o=0.
- Grant latency is 0 cycles, combinational from req_i. Response latency is exactly 1 cycle after the grant.
- Throughput is one access per cycle, back-to-back, with no bubble between different masters.
- Zero-fill takes exactly BANK_SIZE cycles of INIT. init_done_o is asserted in cycle BANK_SIZE+1 after the init_req_i cycle.
- Reset asserted mid-INIT aborts immediately: state=ARB with all reset values. The bank is left partially cleared, and no init_done_o pulse is generated.
- Reset asserted with a response pending drops the response: r_valid_o=0.
- Counter arithmetic is ADDR_WIDTH bits wide. The terminal compare is against BANK_SIZE-1, so there is no wrap even when BANK_SIZE = 2**ADDR_WIDTH.

## Test plan
- Single master: master 2 reads addr 0x10, following a write of 0xDEADBEEF with be=0xF to the same address.
  - Required: gnt_o=4'b0100 in the same cycle as req; r_valid_o[2] the next cycle with r_rdata_o=0xDEADBEEF.
- All four masters hold req_i continuously for 8 cycles, starting right after reset.
  - Required: grant order 0,1,2,3,0,1,2,3; exactly one gnt bit per cycle; each r_valid_o one cycle after its grant.
- Fairness with a hole: masters 1 and 3 request continuously and rr_q=2.
  - Required: grants alternate 3,1,3,1; master 0 and master 2 never granted.
- Zero-fill with BANK_SIZE=16: write nonzero data to all 16 words, then pulse init_req_i while master 0 requests.
  - Required: master 0 granted in the init_req cycle; 16 INIT cycles with addr 0..15, wdata 0, be 0xF, gnt_o=0; init_done_o in the next cycle; reads of all 16 words return 0.
- init_req_i pulsed again during INIT.
  - Required: no extension. Exactly BANK_SIZE writes, then a single init_done_o pulse.
- Reset asserted at INIT cycle 5.
  - Required: init_busy_o=0 immediately, no init_done_o, a subsequent request is granted with rr_q=0 priority, words 0..4 read 0, and words 5..15 keep their old data.
